tt_um_jleugeri_ttt_step_scheduler: RTL and testbench

//  Sequences the ttt main core through timesteps: buffers host input events in a FIFO, feeds

---
 rtl/tt_um_jleugeri_ttt_step_scheduler.sv | 249 ++++++++++++++++++++++++
 tb/tb_tt_um_jleugeri_ttt_step_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_jleugeri_ttt_step_scheduler.sv
// Timestep scheduler for the ttt main core: buffers host events, feeds them as INPUT
// instructions, issues ADVANCE, then waits for the core to settle. Optional watchdog: TTT_SCHED_WATCHDOG_EN.
module tt_um_jleugeri_ttt_step_scheduler #(
  parameter int NUM_PROCESSORS = 10,
  parameter int NEW_TOKEN_BITS = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TICK_BITS      = 8,
  parameter int STEP_CNT_BITS  = 16,
  parameter int WDT_BITS       = 10,
  localparam int PIDW          = $clog2(NUM_PROCESSORS + 1)
) (
  input  logic                             clock_fast,
  input  logic                             reset,
  input  logic                             ev_valid,
  output logic                             ev_ready,
  input  logic [PIDW-1:0]                  ev_processor_id,
  input  logic signed [NEW_TOKEN_BITS-1:0] ev_good,
  input  logic signed [NEW_TOKEN_BITS-1:0] ev_bad,
  input  logic                             run_en,
  input  logic [TICK_BITS-1:0]             tick_period,
  input  logic                             step_req,
  input  logic [1:0]                       core_stage,
  output logic [3:0]                       instruction,
  output logic [PIDW-1:0]                  processor_id_in,
  output logic signed [NEW_TOKEN_BITS-1:0] good_tokens_in,
  output logic signed [NEW_TOKEN_BITS-1:0] bad_tokens_in,
  output logic                             busy,
  output logic [STEP_CNT_BITS-1:0]         step_count,
  output logic                             step_overrun,
  output logic                             wdt_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [3:0] INSTR_NOP     = 4'b0000;
  localparam logic [3:0] INSTR_INPUT   = 4'b0001;
  localparam logic [3:0] INSTR_ADVANCE = 4'b0010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_ADVANCE,
    ST_WAIT_LEAVE,
    ST_WAIT_RETURN
  } state_e;

  typedef struct packed {
    logic [PIDW-1:0]           pid;
    logic [NEW_TOKEN_BITS-1:0] good;
    logic [NEW_TOKEN_BITS-1:0] bad;
  } event_t;

  event_t                     fifo_mem_q [FIFO_DEPTH];
  event_t                     head;
  logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       ev_ready_q, ev_ready_d;
  logic                       push, pop;

  state_e                     state_q, state_d;
  logic [CW-1:0]              feed_rem_q, feed_rem_d;
  logic [3:0]                 instr_q, instr_d;
  logic [PIDW-1:0]            pid_q, pid_d;
  logic [NEW_TOKEN_BITS-1:0]  good_q, good_d, bad_q, bad_d;
  logic [TICK_BITS-1:0]       tick_cnt_q, tick_cnt_d;
  logic                       tick, trigger, start;
  logic                       step_pending_q, step_pending_d;
  logic                       overrun_q, overrun_d;
  logic [STEP_CNT_BITS-1:0]   step_cnt_q, step_cnt_d;

`ifdef TTT_SCHED_WATCHDOG_EN
  logic [WDT_BITS-1:0]        wdt_cnt_q, wdt_cnt_d;
  logic                       wdt_err_q, wdt_err_d;
`endif

  // Event handshake: a transfer happens on a clock edge where ev_valid and ev_ready are both 1;
  // ev_ready is a registered copy of "FIFO not full" and ignores same-cycle pops.
  assign push = ev_valid & ev_ready_q;
  assign head = fifo_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ev_ready_d = (count_d != FULL_CNT);
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick       = 1'b0;
    if (run_en && (tick_period != '0)) begin
      if (tick_cnt_q >= tick_period - 1'b1) begin
        tick_cnt_d = '0;
        tick       = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  // A trigger landing on the cycle the pending step is consumed re-arms it instead of overrunning.
  assign trigger = tick | step_req;

  always_comb begin
    step_pending_d = step_pending_q & ~start;
    overrun_d      = overrun_q;
    if (trigger) begin
      if (step_pending_q && !start) overrun_d = 1'b1;
      step_pending_d = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    feed_rem_d = feed_rem_q;
    step_cnt_d = step_cnt_q;
    instr_d    = INSTR_NOP;
    pid_d      = '0;
    good_d     = '0;
    bad_d      = '0;
    pop        = 1'b0;
    start      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (step_pending_q && (core_stage == 2'b00)) begin
          start = 1'b1;
          if (count_q != '0) begin
            pop        = 1'b1;
            feed_rem_d = count_q - 1'b1;
            state_d    = ST_FEED;
          end else begin
            instr_d = INSTR_ADVANCE;
            state_d = ST_ADVANCE;
          end
        end
      end
      ST_FEED: begin
        if (feed_rem_q != '0) begin
          pop        = 1'b1;
          feed_rem_d = feed_rem_q - 1'b1;
        end else begin
          instr_d = INSTR_ADVANCE;
          state_d = ST_ADVANCE;
        end
      end
      ST_ADVANCE:    state_d = ST_WAIT_LEAVE;
      ST_WAIT_LEAVE: if (core_stage != 2'b00) state_d = ST_WAIT_RETURN;
      ST_WAIT_RETURN: begin
        if (core_stage == 2'b00) begin
          step_cnt_d = step_cnt_q + 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      instr_d = INSTR_INPUT;
      pid_d   = head.pid;
      good_d  = head.good;
      bad_d   = head.bad;
    end
`ifdef TTT_SCHED_WATCHDOG_EN
    // A normal wait exit takes priority over a timeout on the same cycle.
    wdt_cnt_d = '0;
    wdt_err_d = wdt_err_q;
    if (((state_q == ST_WAIT_LEAVE) || (state_q == ST_WAIT_RETURN)) && (state_d == state_q)) begin
      if (wdt_cnt_q == '1) begin
        wdt_err_d = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        wdt_cnt_d = wdt_cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clock_fast) begin
    if (push) fifo_mem_q[wr_ptr_q] <= '{pid: ev_processor_id, good: ev_good, bad: ev_bad};
  end

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ev_ready_q     <= 1'b0;
      state_q        <= ST_IDLE;
      feed_rem_q     <= '0;
      instr_q        <= INSTR_NOP;
      pid_q          <= '0;
      good_q         <= '0;
      bad_q          <= '0;
      tick_cnt_q     <= '0;
      step_pending_q <= 1'b0;
      overrun_q      <= 1'b0;
      step_cnt_q     <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ev_ready_q     <= ev_ready_d;
      state_q        <= state_d;
      feed_rem_q     <= feed_rem_d;
      instr_q        <= instr_d;
      pid_q          <= pid_d;
      good_q         <= good_d;
      bad_q          <= bad_d;
      tick_cnt_q     <= tick_cnt_d;
      step_pending_q <= step_pending_d;
      overrun_q      <= overrun_d;
      step_cnt_q     <= step_cnt_d;
    end
  end

`ifdef TTT_SCHED_WATCHDOG_EN
  always_ff @(posedge clock_fast) begin
    if (reset) begin
      wdt_cnt_q <= '0;
      wdt_err_q <= 1'b0;
    end else begin
      wdt_cnt_q <= wdt_cnt_d;
      wdt_err_q <= wdt_err_d;
    end
  end
  assign wdt_error = wdt_err_q;
`else
  logic unused_wdt_bits;
  assign unused_wdt_bits = ^WDT_BITS;
  assign wdt_error       = 1'b0;
`endif

  assign ev_ready        = ev_ready_q;
  assign instruction     = instr_q;
  assign processor_id_in = pid_q;
  assign good_tokens_in  = good_q;
  assign bad_tokens_in   = bad_q;
  assign busy            = (state_q != ST_IDLE);
  assign step_count      = step_cnt_q;
  assign step_overrun    = overrun_q;

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_step_scheduler.sv
// Bench for the step scheduler: a step-level reference model checked every cycle,
// plus directed literal checks on the event sequence, full FIFO, ticks, overrun and stuck core.
`timescale 1ns/1ps
module tb_tt_um_jleugeri_ttt_step_scheduler;

  localparam int DEPTH   = 4;
  localparam int WDT_MAX = (1 << 10) - 1;

  logic        clock_fast = 1'b0;
  logic        reset = 1'b1;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic [3:0]  ev_processor_id = '0;
  logic [3:0]  ev_good = '0;
  logic [3:0]  ev_bad = '0;
  logic        run_en = 1'b0;
  logic [7:0]  tick_period = '0;
  logic        step_req = 1'b0;
  logic [1:0]  core_stage = 2'b01;
  logic [3:0]  instruction;
  logic [3:0]  processor_id_in;
  logic [3:0]  good_tokens_in;
  logic [3:0]  bad_tokens_in;
  logic        busy;
  logic [15:0] step_count;
  logic        step_overrun;
  logic        wdt_error;

  int checks = 0;
  int failures = 0;

  tt_um_jleugeri_ttt_step_scheduler dut (
    .clock_fast      (clock_fast),
    .reset           (reset),
    .ev_valid        (ev_valid),
    .ev_ready        (ev_ready),
    .ev_processor_id (ev_processor_id),
    .ev_good         (ev_good),
    .ev_bad          (ev_bad),
    .run_en          (run_en),
    .tick_period     (tick_period),
    .step_req        (step_req),
    .core_stage      (core_stage),
    .instruction     (instruction),
    .processor_id_in (processor_id_in),
    .good_tokens_in  (good_tokens_in),
    .bad_tokens_in   (bad_tokens_in),
    .busy            (busy),
    .step_count      (step_count),
    .step_overrun    (step_overrun),
    .wdt_error       (wdt_error)
  );

  // ---------------- clock ----------------
  always #5 clock_fast = ~clock_fast;

  // ---------------- reference model ----------------
  // exp_q holds queued events {pid, good, bad}; m_phase: 0 idle, 1 feeding, 2 advance,
  // 3 waiting for core to leave stage 0, 4 waiting for it to return.
  logic [11:0] exp_q[$];
  int          m_phase = 0;
  int          m_nfeed = 0;
  int          m_tick = 0;
  int          m_wdt = 0;
  bit          m_pend = 0, m_ovr = 0, m_ready = 0, m_wdt_err = 0;
  logic [15:0] m_steps = '0;
  logic [15:0] m_out = '0;

  always @(posedge clock_fast) begin : model
    bit          m_push, m_hit, m_start;
    int          old_phase;
    logic [11:0] ev;
    if (reset) begin
      exp_q.delete();
      m_phase = 0; m_nfeed = 0; m_tick = 0; m_wdt = 0;
      m_pend = 0; m_ovr = 0; m_ready = 0; m_wdt_err = 0;
      m_steps = '0; m_out = '0;
    end else begin
      m_push = ev_valid && m_ready;
      m_hit = 0;
      if (run_en && tick_period != 0) begin
        if (m_tick >= int'(tick_period) - 1) begin m_tick = 0; m_hit = 1; end
        else m_tick++;
      end
      m_start = 0;
      m_out = '0;
      old_phase = m_phase;
      case (m_phase)
        0: if (m_pend && core_stage == 2'b00) begin
             m_start = 1; m_nfeed = exp_q.size(); m_phase = 1;
           end
        2: m_phase = 3;
        3: if (core_stage != 2'b00) m_phase = 4;
        4: if (core_stage == 2'b00) begin m_steps++; m_phase = 0; end
        default: ;
      endcase
`ifdef TTT_SCHED_WATCHDOG_EN
      if ((old_phase == 3 || old_phase == 4) && m_phase == old_phase) begin
        if (m_wdt == WDT_MAX) begin m_wdt_err = 1; m_phase = 0; m_wdt = 0; end
        else m_wdt++;
      end else m_wdt = 0;
`endif
      if (m_phase == 1) begin
        if (m_nfeed > 0) begin
          ev = exp_q.pop_front();
          m_out = {4'b0001, ev};
          m_nfeed--;
        end else begin
          m_out = {4'b0010, 12'h000};
          m_phase = 2;
        end
      end
      if (m_start) m_pend = 0;
      if (m_hit || step_req) begin
        if (m_pend) m_ovr = 1;
        m_pend = 1;
      end
      if (m_push) exp_q.push_back({ev_processor_id, ev_good, ev_bad});
      m_ready = (exp_q.size() < DEPTH);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock_fast) begin
    check("instruction", instruction, m_out[15:12]);
    check("processor_id_in", processor_id_in, m_out[11:8]);
    check("good_tokens_in", good_tokens_in, m_out[7:4]);
    check("bad_tokens_in", bad_tokens_in, m_out[3:0]);
    check("ev_ready", ev_ready, m_ready);
    check("busy", busy, m_phase != 0);
    check("step_count", step_count, m_steps);
    check("step_overrun", step_overrun, m_ovr);
    check("wdt_error", wdt_error, m_wdt_err);
  end

  // ---------------- core responder ----------------
  bit core_auto = 1;
  int core_lat = 12;

  initial begin
    forever begin
      @(negedge clock_fast);
      if (core_auto && instruction == 4'b0010) begin
        @(posedge clock_fast); #2 core_stage = 2'b01;
        repeat (core_lat) @(posedge clock_fast);
        #2 core_stage = 2'b00;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic align();
    @(posedge clock_fast); #2;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock_fast);
    #2;
  endtask

  task automatic pulse_step();
    step_req = 1'b1;
    wait_cycles(1);
    step_req = 1'b0;
  endtask

  task automatic push_event(input logic [3:0] pid, input logic [3:0] g, input logic [3:0] b);
    int n = 0;
    ev_valid = 1'b1; ev_processor_id = pid; ev_good = g; ev_bad = b;
    do begin @(negedge clock_fast); n++; end while (!ev_ready && n < 200);
    if (!ev_ready) begin
      checks++; failures++;
      $display("FAIL push_event: ev_ready=0 after %0d cycles, required 1", n);
    end
    align();
    ev_valid = 1'b0;
  endtask

  task automatic wait_instr(input logic [3:0] want, input int max_cyc);
    int n = 0;
    do begin @(negedge clock_fast); n++; end while (instruction != want && n < max_cyc);
    if (instruction != want) begin
      checks++; failures++;
      $display("FAIL wait_instr: instruction=%0h after %0d cycles, required %0h", instruction, n, want);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    do begin @(negedge clock_fast); n++; end while (busy && n < max_cyc);
    if (busy) begin
      checks++; failures++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, required 0", n);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset for 3 cycles with the core still busy.
    @(negedge clock_fast);
    check("rst_instruction", instruction, 4'b0000);
    check("rst_ev_ready", ev_ready, 1'b0);
    check("rst_step_count", step_count, 16'd0);
    repeat (2) @(posedge clock_fast);
    #2 reset = 1'b0;
    @(negedge clock_fast);
    check("ev_ready_first_edge", ev_ready, 1'b0);
    @(negedge clock_fast);
    check("ev_ready_second_edge", ev_ready, 1'b1);
    align();

    // Step requested while core stage is 01: must hold in IDLE.
    pulse_step();
    wait_cycles(3);
    @(negedge clock_fast);
    check("hold_busy", busy, 1'b0);
    check("hold_instruction", instruction, 4'b0000);
    align();
    core_stage = 2'b00;
    wait_instr(4'b0010, 10);
    wait_idle(100);
    check("empty_step_count", step_count, 16'd1);
    align();

    // Three events fed in order, then one advance.
    push_event(4'd2, 4'd3, 4'd1);
    push_event(4'd5, 4'hF, 4'hE);
    push_event(4'd9, 4'd7, 4'd0);
    pulse_step();
    wait_instr(4'b0001, 10);
    check("ev0_pid", processor_id_in, 4'd2);
    check("ev0_good", good_tokens_in, 4'd3);
    check("ev0_bad", bad_tokens_in, 4'd1);
    @(negedge clock_fast);
    check("ev1_instr", instruction, 4'b0001);
    check("ev1_pid", processor_id_in, 4'd5);
    check("ev1_good", good_tokens_in, 4'hF);
    @(negedge clock_fast);
    check("ev2_pid", processor_id_in, 4'd9);
    check("ev2_good", good_tokens_in, 4'd7);
    @(negedge clock_fast);
    check("ev_advance", instruction, 4'b0010);
    wait_idle(100);
    check("three_ev_step_count", step_count, 16'd2);
    align();

    // Fill the FIFO, then offer a fifth event while the feed drains it.
    push_event(4'd1, 4'd1, 4'd1);
    push_event(4'd2, 4'd2, 4'd2);
    push_event(4'd3, 4'd3, 4'd3);
    push_event(4'd4, 4'd4, 4'd4);
    @(negedge clock_fast);
    check("full_ev_ready", ev_ready, 1'b0);
    align();
    fork
      push_event(4'd10, 4'h8, 4'h7);
      pulse_step();
    join
    wait_idle(100);
    check("full_step_count", step_count, 16'd3);
    align();
    pulse_step();
    wait_instr(4'b0001, 10);
    check("fifth_pid", processor_id_in, 4'd10);
    check("fifth_good", good_tokens_in, 4'h8);
    wait_idle(100);
    check("fifth_step_count", step_count, 16'd4);
    align();

    // Tick divider: period 20, core returns in 8 cycles.
    core_lat = 8;
    tick_period = 8'd20;
    run_en = 1'b1;
    wait_cycles(75);
    run_en = 1'b0;
    wait_idle(50);
    check("tick_step_count", step_count, 16'd7);
    align();

    // Overrun: second request while the first is still pending on a busy core.
    core_auto = 0;
    core_stage = 2'b01;
    pulse_step();
    wait_cycles(2);
    @(negedge clock_fast);
    check("no_overrun_yet", step_overrun, 1'b0);
    align();
    pulse_step();
    @(negedge clock_fast);
    check("overrun_set", step_overrun, 1'b1);
    align();
    core_auto = 1;
    core_stage = 2'b00;
    wait_instr(4'b0010, 10);
    wait_idle(100);
    check("overrun_step_count", step_count, 16'd8);
    align();

    // Core stuck after advance.
    core_auto = 0;
    pulse_step();
    wait_instr(4'b0010, 10);
    align();
    core_stage = 2'b01;
    wait_cycles(1100);
    @(negedge clock_fast);
`ifdef TTT_SCHED_WATCHDOG_EN
    check("stuck_wdt_error", wdt_error, 1'b1);
    check("stuck_busy", busy, 1'b0);
    check("stuck_step_count", step_count, 16'd8);
`else
    check("stuck_busy", busy, 1'b1);
    check("stuck_wdt_error", wdt_error, 1'b0);
`endif
    align();
    core_stage = 2'b00;
    wait_idle(20);
`ifdef TTT_SCHED_WATCHDOG_EN
    check("final_step_count", step_count, 16'd8);
`else
    check("final_step_count", step_count, 16'd9);
`endif
    wait_cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
